// File: rtl/gametang_bus_pkg.sv
// Shared bus-side types and defaults for the CPU/memory arbiter and its DMA copy engine.
package gametang_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RD,
        ST_CAP,
        ST_WR
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
    localparam logic [15:0] DST_BASE_DEF     = 16'hFE00;
    localparam int unsigned LEN_DEF          = 160;
    localparam logic [7:0]  BUS_OPEN         = 8'hFF;

    typedef struct packed {
        logic [15:0] ab;
        logic [7:0]  db;
        logic        n_rd;
        logic        n_wr;
    } bus_cycle_t;

endpackage

// File: rtl/dma_copy_engine.sv
// Block-copy sequencer: reads LEN bytes from one page and writes them to DST_BASE,
// one byte every three cycles after a single dead ARM cycle.
module dma_copy_engine
    import gametang_bus_pkg::*;
#(
    parameter logic [15:0] DST_BASE = DST_BASE_DEF,
    parameter int unsigned LEN      = LEN_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] page_i,
    input  logic [7:0] rdata_i,
    output bus_cycle_t bus_c_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] page_o
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    dma_state_t state_q;
    logic [7:0] idx_q;
    logic [7:0] page_q;
    logic [7:0] latch_q;
    logic       busy_q;
    logic       done_q;

    // busy/done are updated on the same edges as the state so they never lag it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            latch_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        page_q  <= page_i;
                        idx_q   <= 8'h00;
                        busy_q  <= 1'b1;
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: state_q <= ST_RD;
                ST_RD:  state_q <= ST_CAP;
                ST_CAP: begin
                    latch_q <= rdata_i;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + 8'h01;
                        state_q <= ST_RD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory cycle driven in the current state; strobes idle high outside RD/WR
    always_comb begin
        bus_c_o.ab   = 16'h0000;
        bus_c_o.db   = latch_q;
        bus_c_o.n_rd = 1'b1;
        bus_c_o.n_wr = 1'b1;
        unique case (state_q)
            ST_RD: begin
                bus_c_o.ab   = {page_q, idx_q};
                bus_c_o.n_rd = 1'b0;
            end
            ST_WR: begin
                bus_c_o.ab   = DST_BASE + 16'(idx_q);
                bus_c_o.n_wr = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign page_o = page_q;

endmodule

// File: rtl/bus_dma_arbiter.sv
// CPU/DMA arbiter for the shared system memory: passes CPU cycles through when idle,
// decodes the DMA trigger register and hands the bus to the copy engine while busy.
module bus_dma_arbiter
    import gametang_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DST_BASE     = DST_BASE_DEF,
    parameter int unsigned LEN          = LEN_DEF
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic [15:0] cpu_AB,
    input  logic [7:0]  cpu_DB,
    input  logic        cpu_nRD,
    input  logic        cpu_nWR,
    output logic [7:0]  cpu_DB_IN,
    output logic        cpu_RDY,
    output logic [15:0] mem_AB,
    output logic [7:0]  mem_DB,
    output logic        mem_nRD,
    output logic        mem_nWR,
    input  logic [7:0]  mem_DB_IN,
    output logic        dma_busy,
    output logic        dma_done
);

    bus_cycle_t eng_bus;
    logic       eng_busy;
    logic [7:0] src_page;
    logic       reg_hit_c;
    logic       start_c;
    logic       reg_rd_q;
    logic       blk_rd_q;

    assign reg_hit_c = (cpu_AB == DMA_REG_ADDR);
    assign start_c   = !eng_busy && !cpu_nWR && reg_hit_c;

    dma_copy_engine #(
        .DST_BASE (DST_BASE),
        .LEN      (LEN)
    ) u_engine (
        .clk_i   (Clk),
        .rst_ni  (nRst),
        .start_i (start_c),
        .page_i  (cpu_DB),
        .rdata_i (mem_DB_IN),
        .bus_c_o (eng_bus),
        .busy_o  (eng_busy),
        .done_o  (dma_done),
        .page_o  (src_page)
    );

    // Remember what kind of CPU read was issued so next cycle's data can be steered
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            reg_rd_q <= 1'b0;
            blk_rd_q <= 1'b0;
        end else begin
            reg_rd_q <= !eng_busy && !cpu_nRD && reg_hit_c;
            blk_rd_q <= eng_busy && !cpu_nRD;
        end
    end

    // Register accesses never reach memory; strobes are forced idle during reset
    always_comb begin
        mem_AB  = cpu_AB;
        mem_DB  = cpu_DB;
        mem_nRD = cpu_nRD | reg_hit_c;
        mem_nWR = cpu_nWR | reg_hit_c;
        if (eng_busy) begin
            mem_AB  = eng_bus.ab;
            mem_DB  = eng_bus.db;
            mem_nRD = eng_bus.n_rd;
            mem_nWR = eng_bus.n_wr;
        end
        if (!nRst) begin
            mem_nRD = 1'b1;
            mem_nWR = 1'b1;
        end
    end

    always_comb begin
        cpu_DB_IN = mem_DB_IN;
        if (reg_rd_q) begin
            cpu_DB_IN = src_page;
        end else if (blk_rd_q) begin
            cpu_DB_IN = BUS_OPEN;
        end
    end

    assign dma_busy = eng_busy;
    assign cpu_RDY  = !eng_busy;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed bench for bus_dma_arbiter (LEN=4) with a cycle-offset reference model
// and a simple one-cycle-latency memory behind the arbiter.
module tb_bus_dma_arbiter;

    localparam int unsigned TB_LEN = 4;
    localparam logic [15:0] REG_A  = 16'hFF46;
    localparam logic [15:0] DST_A  = 16'hFE00;

    logic        Clk = 1'b0;
    logic        nRst;
    logic [15:0] cpu_AB;
    logic [7:0]  cpu_DB;
    logic        cpu_nRD;
    logic        cpu_nWR;
    logic [7:0]  cpu_DB_IN;
    logic        cpu_RDY;
    logic [15:0] mem_AB;
    logic [7:0]  mem_DB;
    logic        mem_nRD;
    logic        mem_nWR;
    logic [7:0]  mem_DB_IN = 8'h00;
    logic        dma_busy;
    logic        dma_done;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bus_dma_arbiter #(
        .DMA_REG_ADDR (REG_A),
        .DST_BASE     (DST_A),
        .LEN          (TB_LEN)
    ) dut (
        .Clk       (Clk),
        .nRst      (nRst),
        .cpu_AB    (cpu_AB),
        .cpu_DB    (cpu_DB),
        .cpu_nRD   (cpu_nRD),
        .cpu_nWR   (cpu_nWR),
        .cpu_DB_IN (cpu_DB_IN),
        .cpu_RDY   (cpu_RDY),
        .mem_AB    (mem_AB),
        .mem_DB    (mem_DB),
        .mem_nRD   (mem_nRD),
        .mem_nWR   (mem_nWR),
        .mem_DB_IN (mem_DB_IN),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Memory: read data appears the cycle after the strobe
    always @(posedge Clk) begin
        if (!mem_nRD) mem_DB_IN <= mem[mem_AB];
        if (!mem_nWR) mem[mem_AB] <= mem_DB;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: DMA activity expressed as offset k from the trigger cycle
    bit          m_active = 1'b0;
    int          m_k      = 0;
    logic [7:0]  m_page   = 8'h00;
    int          m_prev   = 0;
    logic [7:0]  m_prev_data = 8'h00;
    bit          m_done   = 1'b0;

    always @(negedge Clk) begin
        bit          nxt_done;
        bit          hit;
        logic        e_nrd, e_nwr;
        logic [15:0] e_ab, src;
        int          j, i;
        if (!nRst) begin
            chk("rst_mem_nrd", 32'(mem_nRD), 32'd1);
            chk("rst_mem_nwr", 32'(mem_nWR), 32'd1);
            m_active = 1'b0; m_k = 0; m_page = 8'h00; m_prev = 0; m_done = 1'b0;
        end else begin
            hit = (cpu_AB == REG_A);
            chk("m_rdy",  32'(cpu_RDY),  32'(!m_active));
            chk("m_busy", 32'(dma_busy), 32'(m_active));
            chk("m_done", 32'(dma_done), 32'(m_done));
            case (m_prev)
                1: chk("m_rdata_mem", 32'(cpu_DB_IN), 32'(m_prev_data));
                2: chk("m_rdata_reg", 32'(cpu_DB_IN), 32'(m_page));
                3: chk("m_rdata_blk", 32'(cpu_DB_IN), 32'h0000_00FF);
                default: ;
            endcase
            e_nrd = 1'b1; e_nwr = 1'b1; e_ab = 16'h0000; src = 16'h0000; j = 1; i = 0;
            if (m_active) begin
                if (m_k >= 2) begin
                    j   = (m_k - 2) % 3;
                    i   = (m_k - 2) / 3;
                    src = {m_page, 8'(i)};
                    if (j == 0) begin e_nrd = 1'b0; e_ab = src; end
                    if (j == 2) begin e_nwr = 1'b0; e_ab = DST_A + 16'(i); end
                end
                chk("m_dma_nrd", 32'(mem_nRD), 32'(e_nrd));
                chk("m_dma_nwr", 32'(mem_nWR), 32'(e_nwr));
                if (!e_nrd || !e_nwr) chk("m_dma_ab", 32'(mem_AB), 32'(e_ab));
                if (!e_nwr) chk("m_dma_db", 32'(mem_DB), 32'(ref_mem[src]));
            end else begin
                chk("m_pt_nrd", 32'(mem_nRD), 32'(cpu_nRD | hit));
                chk("m_pt_nwr", 32'(mem_nWR), 32'(cpu_nWR | hit));
                if (!hit && (!cpu_nRD || !cpu_nWR)) chk("m_pt_ab", 32'(mem_AB), 32'(cpu_AB));
                if (!hit && !cpu_nWR) chk("m_pt_db", 32'(mem_DB), 32'(cpu_DB));
            end
            // advance the model to the next cycle
            nxt_done = 1'b0;
            m_prev   = 0;
            if (!cpu_nRD) begin
                if (m_active) m_prev = 3;
                else if (hit) m_prev = 2;
                else begin m_prev = 1; m_prev_data = ref_mem[cpu_AB]; end
            end
            if (m_active) begin
                if (m_k >= 2 && j == 2) ref_mem[DST_A + 16'(i)] = ref_mem[src];
                m_k++;
                if (m_k == 2 + 3 * int'(TB_LEN)) begin
                    m_active = 1'b0;
                    nxt_done = 1'b1;
                end
            end else if (!cpu_nWR) begin
                if (hit) begin m_active = 1'b1; m_k = 1; m_page = cpu_DB; end
                else ref_mem[cpu_AB] = cpu_DB;
            end
            m_done = nxt_done;
        end
    end

    // Set CPU inputs for the next cycle
    task automatic drive(input logic [15:0] ab, input logic [7:0] db, input logic nrd, input logic nwr);
        @(posedge Clk);
        #1;
        cpu_AB = ab; cpu_DB = db; cpu_nRD = nrd; cpu_nWR = nwr;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(16'h0000, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge Clk);
            if (dma_done) seen = 1'b1;
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    initial begin
        int t0;
        bit seen;
        logic [7:0] exp_b [4];
        bit exp_rd, exp_wr;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h8000] = 8'h48; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33; mem[16'h8003] = 8'h44;
        for (int a = 0; a < 4; a++) begin
            mem[16'h8100 + 16'(a)] = 8'h91 + 8'(a);
            mem[16'h8200 + 16'(a)] = 8'hA1 + 8'(a);
            mem[16'hC100 + 16'(a)] = 8'hC0 + 8'(a);
        end
        mem[16'h0300] = 8'h5A;
        for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];

        nRst = 1'b0; cpu_AB = 16'h0000; cpu_DB = 8'h00; cpu_nRD = 1'b1; cpu_nWR = 1'b1;
        repeat (2) @(posedge Clk);
        #1 nRst = 1'b1;
        @(negedge Clk);
        chk("reset_rdy",  32'(cpu_RDY),  32'd1);
        chk("reset_busy", 32'(dma_busy), 32'd0);
        chk("reset_done", 32'(dma_done), 32'd0);

        // pass-through read then write
        drive(16'h8000, 8'h00, 1'b0, 1'b1);
        @(negedge Clk);
        chk("pt_rd_ab",  32'(mem_AB),  32'h8000);
        chk("pt_rd_nrd", 32'(mem_nRD), 32'd0);
        drive(16'h0200, 8'h55, 1'b1, 1'b0);
        @(negedge Clk);
        chk("pt_rdata",  32'(cpu_DB_IN), 32'h48);
        chk("pt_wr_nwr", 32'(mem_nWR),   32'd0);
        chk("pt_wr_db",  32'(mem_DB),    32'h55);
        chk("pt_wr_ab",  32'(mem_AB),    32'h0200);
        drive(16'h8000, 8'h11, 1'b1, 1'b0);
        idle(1);

        // copy of page 80h with literal timing
        drive(REG_A, 8'h80, 1'b1, 1'b0);
        @(negedge Clk);
        chk("trig_not_fwd", 32'(mem_nWR), 32'd1);
        idle(1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge Clk);
            exp_rd = (k >= 2) && (k <= 11) && ((k - 2) % 3 == 0);
            exp_wr = (k >= 4) && (k <= 13) && ((k - 4) % 3 == 0);
            chk("pin_rdy",  32'(cpu_RDY),  32'(k == 14));
            chk("pin_done", 32'(dma_done), 32'(k == 14));
            chk("pin_nrd",  32'(mem_nRD),  32'(!exp_rd));
            chk("pin_nwr",  32'(mem_nWR),  32'(!exp_wr));
        end
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int a = 0; a < 4; a++) chk("copy80_data", 32'(mem[DST_A + 16'(a)]), 32'(exp_b[a]));

        // blocked CPU accesses and register readback
        drive(REG_A, 8'hC1, 1'b1, 1'b0);
        drive(16'h8000, 8'h00, 1'b0, 1'b1);
        drive(16'h0300, 8'hAA, 1'b1, 1'b0);
        @(negedge Clk);
        chk("blk_rdata", 32'(cpu_DB_IN), 32'hFF);
        drive(REG_A, 8'h90, 1'b1, 1'b0);
        idle(1);
        wait_done(40);
        drive(REG_A, 8'h00, 1'b0, 1'b1);
        @(negedge Clk);
        chk("regrd_no_mem", 32'(mem_nRD), 32'd1);
        idle(1);
        @(negedge Clk);
        chk("regrd_data", 32'(cpu_DB_IN), 32'hC1);
        chk("blk_wr_dropped", 32'(mem[16'h0300]), 32'h5A);
        exp_b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        for (int a = 0; a < 4; a++) chk("copyC1_data", 32'(mem[DST_A + 16'(a)]), 32'(exp_b[a]));

        // reset abort after byte 1 is written
        drive(REG_A, 8'h82, 1'b1, 1'b0);
        idle(8);
        nRst = 1'b0;
        idle(1);
        nRst = 1'b1;
        @(negedge Clk);
        chk("abort_rdy",  32'(cpu_RDY),  32'd1);
        chk("abort_busy", 32'(dma_busy), 32'd0);
        chk("abort_done", 32'(dma_done), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (dma_done) seen = 1'b1;
        end
        chk("abort_no_done_later", 32'(seen), 32'd0);
        chk("abort_b0", 32'(mem[16'hFE00]), 32'hA1);
        chk("abort_b1", 32'(mem[16'hFE01]), 32'hA2);
        chk("abort_b2", 32'(mem[16'hFE02]), 32'hC2);

        // retrigger in the done cycle
        drive(REG_A, 8'h80, 1'b1, 1'b0);
        t0 = cyc;
        idle(13);
        drive(REG_A, 8'h81, 1'b1, 1'b0);
        @(negedge Clk);
        chk("b2b_done_cycle", 32'(dma_done), 32'd1);
        chk("b2b_done_offset", 32'(cyc - t0), 32'd14);
        idle(1);
        @(negedge Clk);
        chk("b2b_arm_busy", 32'(dma_busy), 32'd1);
        chk("b2b_arm_rdy",  32'(cpu_RDY),  32'd0);
        wait_done(40);
        exp_b = '{8'h91, 8'h92, 8'h93, 8'h94};
        for (int a = 0; a < 4; a++) chk("copy81_data", 32'(mem[DST_A + 16'(a)]), 32'(exp_b[a]));

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_dma_arbiter.md
Name: bus_dma_arbiter

Overview:
- Sits between the 6502-style CPU bus (AB/DB/nRD/nWR/DB_IN) and the shared system memory.
- Idle: forwards CPU cycles to memory unchanged.
- A CPU write to the DMA trigger register starts a block copy of LEN bytes from page {src_page,00h} to DST_BASE.
- During the copy the arbiter owns the memory bus, deasserts cpu_RDY, and blocks all CPU accesses.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA trigger/page register.
- DST_BASE, 16'hFE00, destination base address of the copy.
- LEN, 160, bytes per transfer (1..256).

Ports:
- Clk  in  1  system clock
- nRst  in  1  synchronous active-low reset
- cpu_AB  in  16  CPU address
- cpu_DB  in  8  CPU write data
- cpu_nRD  in  1  CPU read strobe, active low
- cpu_nWR  in  1  CPU write strobe, active low
- cpu_DB_IN  out  8  read data returned to CPU
- cpu_RDY  out  1  1 = CPU bus granted; 0 = stalled by DMA
- mem_AB  out  16  memory address
- mem_DB  out  8  memory write data
- mem_nRD  out  1  memory read strobe, active low
- mem_nWR  out  1  memory write strobe, active low
- mem_DB_IN  in  8  memory read data
- dma_busy  out  1  DMA in progress
- dma_done  out  1  one-cycle pulse on completion

Behaviour:
- Clocking and reset:
  - One clock, Clk.
  - nRst is sampled synchronously on the Clk rising edge.
  - While nRst=0 at an edge: state=IDLE, byte index=0, src_page=00h, data latch=00h, cpu_RDY=1, dma_busy=0, dma_done=0, reg-read flag=0.
  - mem_nRD=mem_nWR=1 is forced for the whole reset cycle.
- Memory timing: read data for a strobe issued in cycle N is valid on mem_DB_IN during cycle N+1. The same rule applies to CPU reads.
- States: IDLE, ARM, RD, CAP, WR.
- IDLE:
  - mem_AB/mem_DB/mem_nRD/mem_nWR = cpu_* (combinational pass-through).
  - cpu_DB_IN = mem_DB_IN.
- Trigger (IDLE, cpu_nWR=0, cpu_AB=DMA_REG_ADDR):
  - mem_nWR is held at 1; the register is not forwarded to memory.
  - src_page<=cpu_DB; index<=0; next state ARM.
- DMA_REG read (IDLE, cpu_nRD=0, cpu_AB=DMA_REG_ADDR):
  - mem_nRD is held at 1.
  - A registered flag makes cpu_DB_IN=src_page in the following cycle.
- ARM: one dead cycle with all mem strobes high; then go to RD.
- RD: mem_AB={src_page,index}, mem_nRD=0; then go to CAP.
- CAP: strobes high; data latch<=mem_DB_IN; then go to WR.
- WR:
  - mem_AB=DST_BASE+index (16-bit add, wraps), mem_DB=latch, mem_nWR=0.
  - If index==LEN-1: next state IDLE and dma_done<=1 for one cycle. Otherwise index<=index+1 and next state RD.
- Index is 8 bits. Source address never leaves the page.
- cpu_RDY and dma_busy are registered:
  - cpu_RDY=0 and dma_busy=1 from the cycle after the trigger (ARM) through the last WR cycle inclusive.
  - Both return to 1/0 in the same cycle dma_done pulses.
- Latency: with the trigger written in cycle T, byte i is read in cycle T+2+3i and written in T+4+3i. IDLE and dma_done occur in cycle T+2+3*LEN (LEN=160 gives T+482).
- CPU accesses while busy:
  - Never reach memory.
  - Reads return FFh on cpu_DB_IN in the following cycle.
  - Writes are dropped, including writes to DMA_REG_ADDR (no retrigger, src_page unchanged).
- A trigger in the cycle dma_done pulses (state IDLE) is accepted normally.
- Reset mid-transfer aborts immediately: IDLE, no dma_done pulse, memory strobes high in the reset cycle.

Decomposition:
- Shared package gametang_bus_pkg holds:
  - DMA state enum (IDLE/ARM/RD/CAP/WR);
  - default DMA_REG_ADDR and DST_BASE;
  - BUS_OPEN=8'hFF blocked-read value;
  - bus-cycle struct {AB, DB, nRD, nWR}.
- One natural sub-module, dma_copy_engine: the FSM plus index counter, emitting a bus-cycle struct and busy/done.
- The top level does the mux, register decode and CPU read-data steering.

Test Plan:
- Pass-through: CPU read 8000h while memory returns 48h, then write 55h to 0200h -> mem_AB matches same cycle; cpu_DB_IN=48h next cycle; mem_nWR=0 with mem_DB=55h.
- Copy with LEN=4: preload 8000h..8003h = 11h,22h,33h,44h; CPU writes 80h to FF46h at T -> FE00h..FE03h = 11h..44h. cpu_RDY=0 in T+1..T+13; dma_done pulses at T+14; reads at T+2/5/8/11, writes at T+4/7/10/13.
- Blocked CPU: during DMA, CPU reads 8000h and writes AAh to 0300h -> cpu_DB_IN=FFh; no mem strobe with those addresses; 0300h unchanged.
- Register readback: trigger with C1h, wait for done, read FF46h -> cpu_DB_IN=C1h next cycle; mem_nRD stays 1. A write of 90h to FF46h during busy leaves readback at C1h.
- Reset abort: nRst=0 for one cycle after byte 1 is written -> next cycle state IDLE, cpu_RDY=1, dma_busy=0, no dma_done, FE02h untouched.
- Back-to-back: retrigger with 81h in the dma_done cycle -> second copy starts (ARM next cycle), with correct data from 8100h.
